// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: bypass-mux select codes, register-zero
// constant and default multiply/divide occupancy.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned DEF_DIV_CYCLES = 32;
  localparam int unsigned DEF_MUL_CYCLES = 4;

  // A producer matches a consumer only when it writes the same, non-zero register.
  function automatic logic reg_hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst == src) && (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// Multiply/divide occupancy counter: holds E for the full latency of an
// issued mult/div, starting in the issue cycle itself.
module mdu_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic mdu_stall
);

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);

  logic [5:0] cnt;
  logic       idle;

  assign idle = (cnt == '0);

  // A start seen while the counter is running is the same held instruction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (!idle) begin
      cnt <= cnt - 6'd1;
    end else if (start) begin
      cnt <= is_div ? DIV_LOAD : MUL_LOAD;
    end
  end

  assign busy = !idle;
  // Gated by resetn so the hold drops the instant reset is asserted.
  assign mdu_stall = resetn && (busy || (start && idle));

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard/forwarding controller for the 5-stage pipeline: bypass
// selects, load-use and branch stalls, and mult/div hold sequencing.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       branch_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] wreg_e,
  input  logic [4:0] wreg_m,
  input  logic [4:0] wreg_w,
  input  logic       regwrite_e,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  input  logic       memtoreg_e,
  input  logic       memtoreg_m,
  input  logic       mdu_start_e,
  input  logic       mdu_is_div_e,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       flush_e,
  output logic       mdu_busy
);

  logic alu_m;
  logic lw_stall;
  logic br_stall;
  logic mdu_stall;

  // Only a non-load in M has its result available on the ALU-result bus.
  assign alu_m = regwrite_m && !memtoreg_m;

  assign fwd_a_e = reg_hit(alu_m, wreg_m, rs_e)      ? FWD_MEM :
                   reg_hit(regwrite_w, wreg_w, rs_e) ? FWD_WB  : FWD_RF;
  assign fwd_b_e = reg_hit(alu_m, wreg_m, rt_e)      ? FWD_MEM :
                   reg_hit(regwrite_w, wreg_w, rt_e) ? FWD_WB  : FWD_RF;

  assign fwd_a_d = branch_d && reg_hit(alu_m, wreg_m, rs_d);
  assign fwd_b_d = branch_d && reg_hit(alu_m, wreg_m, rt_d);

  assign lw_stall = memtoreg_e &&
                    (reg_hit(regwrite_e, wreg_e, rs_d) || reg_hit(regwrite_e, wreg_e, rt_d));

  assign br_stall = branch_d &&
                    (reg_hit(regwrite_e, wreg_e, rs_d) || reg_hit(regwrite_e, wreg_e, rt_d) ||
                     reg_hit(memtoreg_m, wreg_m, rs_d) || reg_hit(memtoreg_m, wreg_m, rt_d));

  mdu_seq #(
    .DIV_CYCLES(DIV_CYCLES),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mdu_seq (
    .clk       (clk),
    .resetn    (resetn),
    .start     (mdu_start_e),
    .is_div    (mdu_is_div_e),
    .busy      (mdu_busy),
    .mdu_stall (mdu_stall)
  );

  assign stall_f = lw_stall || br_stall || mdu_stall;
  assign stall_d = stall_f;
  assign stall_e = mdu_stall;
  // A held E register cannot also take a bubble; the hold wins.
  assign flush_e = (lw_stall || br_stall) && !mdu_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
  logic       branch_d, regwrite_e, regwrite_m, regwrite_w;
  logic       memtoreg_e, memtoreg_m, mdu_start_e, mdu_is_div_e;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       fwd_a_d, fwd_b_d, stall_f, stall_d, stall_e, flush_e, mdu_busy;

  int checks = 0;
  int errors = 0;
  int hold_left = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DIV_CYCLES(32), .MUL_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn),
    .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
    .rs_e(rs_e), .rt_e(rt_e),
    .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
    .mdu_start_e(mdu_start_e), .mdu_is_div_e(mdu_is_div_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_e(flush_e), .mdu_busy(mdu_busy)
  );

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, we, wm, ww;
    logic br, re, rm, rw, mte, mtm;
    logic [1:0] fae, fbe;
    logic fad, fbd, stl, fl;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    {rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w} = '0;
    {branch_d, regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m} = '0;
    mdu_start_e = 1'b0;
    mdu_is_div_e = 1'b0;
  endtask

  // Reference: which producer stage (youngest first) supplies a value.
  function automatic int ref_fwd_e(input logic [4:0] src);
    if (src == 0) return 0;
    if (regwrite_m && !memtoreg_m && wreg_m == src) return 2;
    if (regwrite_w && wreg_w == src) return 1;
    return 0;
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return r != 0 && (r == rs_d || r == rt_d);
  endfunction

  // One cycle: model check at negedge, then advance the occupancy model.
  task automatic tick(input string tag);
    bit issued, lw, br, mdu;
    @(negedge clk);
    issued = 0;
    if (hold_left == 0 && mdu_start_e) begin
      hold_left = mdu_is_div_e ? 32 : 4;
      issued = 1;
    end
    mdu = hold_left > 0;
    lw = memtoreg_e && regwrite_e && reads(wreg_e);
    br = branch_d && ((regwrite_e && reads(wreg_e)) || (memtoreg_m && reads(wreg_m)));
    chk({tag, ".fwd_a_e"}, fwd_a_e, ref_fwd_e(rs_e));
    chk({tag, ".fwd_b_e"}, fwd_b_e, ref_fwd_e(rt_e));
    chk({tag, ".fwd_a_d"}, fwd_a_d, int'(ref_fwd_e(rs_d) == 2 && branch_d));
    chk({tag, ".fwd_b_d"}, fwd_b_d, int'(ref_fwd_e(rt_d) == 2 && branch_d));
    chk({tag, ".stall_f"}, stall_f, int'(lw || br || mdu));
    chk({tag, ".stall_d"}, stall_d, int'(lw || br || mdu));
    chk({tag, ".stall_e"}, stall_e, int'(mdu));
    chk({tag, ".flush_e"}, flush_e, int'((lw || br) && !mdu));
    chk({tag, ".mdu_busy"}, mdu_busy, int'(mdu && !issued));
    @(posedge clk);
    if (hold_left > 0) hold_left--;
    #1;
  endtask

  initial begin
    vec_t vt[$];
    int n_st, n_busy;

    clear_inputs();
    resetn = 1'b0;
    #2;
    chk("rst.fwd_a_e", fwd_a_e, 0);
    chk("rst.fwd_b_e", fwd_b_e, 0);
    chk("rst.stall_f", stall_f, 0);
    chk("rst.stall_e", stall_e, 0);
    chk("rst.flush_e", flush_e, 0);
    chk("rst.mdu_busy", mdu_busy, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    tick("post_rst");

    //        rs_d rt_d rs_e rt_e we wm ww  br re rm rw mte mtm  fae   fbe   fad fbd stl fl
    vt.push_back('{0, 0, 3, 3, 0, 3, 0,  0, 0, 1, 0, 0, 0,  2'b10, 2'b10, 0, 0, 0, 0});
    vt.push_back('{0, 0, 3, 3, 0, 3, 3,  0, 0, 1, 1, 0, 0,  2'b10, 2'b10, 0, 0, 0, 0});
    vt.push_back('{0, 0, 3, 4, 0, 0, 3,  0, 0, 0, 1, 0, 0,  2'b01, 2'b00, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0});
    vt.push_back('{0, 0, 6, 6, 0, 6, 6,  0, 0, 1, 1, 0, 1,  2'b01, 2'b01, 0, 0, 0, 0});
    vt.push_back('{5, 0, 0, 0, 5, 0, 0,  0, 1, 0, 0, 1, 0,  2'b00, 2'b00, 0, 0, 1, 1});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0,  2'b00, 2'b00, 0, 0, 0, 0});
    vt.push_back('{7, 0, 0, 0, 7, 0, 0,  1, 1, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 1, 1});
    vt.push_back('{7, 8, 0, 0, 0, 8, 0,  1, 0, 1, 0, 0, 0,  2'b00, 2'b00, 0, 1, 0, 0});
    vt.push_back('{7, 9, 0, 0, 0, 9, 0,  1, 0, 1, 0, 0, 1,  2'b00, 2'b00, 0, 0, 1, 1});
    vt.push_back('{7, 0, 0, 0, 7, 0, 0,  0, 1, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0});
    foreach (vt[i]) begin
      rs_d = vt[i].rs_d; rt_d = vt[i].rt_d; rs_e = vt[i].rs_e; rt_e = vt[i].rt_e;
      wreg_e = vt[i].we; wreg_m = vt[i].wm; wreg_w = vt[i].ww;
      branch_d = vt[i].br; regwrite_e = vt[i].re; regwrite_m = vt[i].rm;
      regwrite_w = vt[i].rw; memtoreg_e = vt[i].mte; memtoreg_m = vt[i].mtm;
      #1;
      chk($sformatf("vec%0d.fwd_a_e", i), fwd_a_e, vt[i].fae);
      chk($sformatf("vec%0d.fwd_b_e", i), fwd_b_e, vt[i].fbe);
      chk($sformatf("vec%0d.fwd_a_d", i), fwd_a_d, vt[i].fad);
      chk($sformatf("vec%0d.fwd_b_d", i), fwd_b_d, vt[i].fbd);
      chk($sformatf("vec%0d.stall_d", i), stall_d, vt[i].stl);
      chk($sformatf("vec%0d.flush_e", i), flush_e, vt[i].fl);
      tick($sformatf("vec%0d", i));
    end

    // Load-use: lw r5 in E, consumer of r5 in D.
    clear_inputs();
    memtoreg_e = 1; regwrite_e = 1; wreg_e = 5; rs_d = 5; #1;
    chk("lu1.stall_f", stall_f, 1);
    chk("lu1.flush_e", flush_e, 1);
    tick("lu1");
    clear_inputs();
    memtoreg_m = 1; regwrite_m = 1; wreg_m = 5; rs_d = 5; #1;
    chk("lu2.stall_f", stall_f, 0);
    chk("lu2.flush_e", flush_e, 0);
    tick("lu2");
    clear_inputs();
    regwrite_w = 1; wreg_w = 5; rs_e = 5; #1;
    chk("lu3.fwd_a_e", fwd_a_e, 1);
    tick("lu3");

    // Branch on r7 behind an add r7.
    clear_inputs();
    branch_d = 1; rs_d = 7; regwrite_e = 1; wreg_e = 7; #1;
    chk("br1.stall_d", stall_d, 1);
    tick("br1");
    clear_inputs();
    branch_d = 1; rs_d = 7; regwrite_m = 1; wreg_m = 7; #1;
    chk("br2.fwd_a_d", fwd_a_d, 1);
    chk("br2.stall_d", stall_d, 0);
    tick("br2");

    // Divide: E held for exactly 32 cycles, busy for 31, never flushed.
    clear_inputs();
    n_st = 0; n_busy = 0;
    for (int i = 0; i < 32; i++) begin
      mdu_start_e = 1; mdu_is_div_e = 1; #1;
      n_st += int'(stall_e); n_busy += int'(mdu_busy);
      tick("div");
    end
    mdu_start_e = 0; #1;
    chk("div.stall_e_cnt", n_st, 32);
    chk("div.busy_cnt", n_busy, 31);
    chk("div.stall_e_after", stall_e, 0);
    tick("div_end");

    // Mult issued under a load-use hazard: hold wins, bubble afterwards.
    clear_inputs();
    memtoreg_e = 1; regwrite_e = 1; wreg_e = 2; rt_d = 2;
    for (int i = 0; i < 4; i++) begin
      mdu_start_e = 1; #1;
      chk("mul_lu.flush_e", flush_e, 0);
      chk("mul_lu.stall_e", stall_e, 1);
      tick("mul_lu");
    end
    mdu_start_e = 0; #1;
    chk("mul_lu_end.flush_e", flush_e, 1);
    chk("mul_lu_end.stall_e", stall_e, 0);
    tick("mul_lu_end");

    // Reset at cycle 10 of a divide.
    clear_inputs();
    mdu_start_e = 1; mdu_is_div_e = 1;
    for (int i = 0; i < 10; i++) tick("div_rst");
    resetn = 1'b0; #1;
    chk("arst.mdu_busy", mdu_busy, 0);
    chk("arst.stall_e", stall_e, 0);
    chk("arst.stall_f", stall_f, 0);
    hold_left = 0;
    @(posedge clk); #1;
    resetn = 1'b1; mdu_start_e = 0; mdu_is_div_e = 0;
    tick("arst_rel");
    n_st = 0;
    for (int i = 0; i < 4; i++) begin
      mdu_start_e = 1; #1;
      n_st += int'(stall_e);
      tick("mul_after_rst");
    end
    mdu_start_e = 0; #1;
    chk("mul_after_rst.cnt", n_st, 4);
    chk("mul_after_rst.stall_e", stall_e, 0);
    tick("mul_after_rst_end");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      wreg_e = 5'($urandom_range(0, 3)); wreg_m = 5'($urandom_range(0, 3));
      wreg_w = 5'($urandom_range(0, 3));
      branch_d = 1'($urandom); regwrite_e = 1'($urandom); regwrite_m = 1'($urandom);
      regwrite_w = 1'($urandom); memtoreg_e = 1'($urandom); memtoreg_m = 1'($urandom);
      mdu_start_e = ($urandom_range(0, 11) == 0);
      mdu_is_div_e = ($urandom_range(0, 3) == 0);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
